load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: decodes RV load/store size codes, lane-aligns data onto a word-wide memory port.
// Optional macro LSU_MISALIGN_SPLIT_EN enables misaligned accesses, splitting word-crossing ones.
module load_store_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_fault,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_be,
  input  logic              mem_ready,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int unsigned NB   = XLEN / 8;
  localparam int unsigned OFFW = $clog2(NB);
  localparam int unsigned BW   = 2 * NB;

  typedef enum logic [1:0] {StIdle, StAccess, StAccess2, StResp} state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              sign_q, sign_d;
  logic [XLEN-1:0]   base_q, base_d;
  logic [OFFW-1:0]   off_q, off_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              cross_q, cross_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [XLEN-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic              rsp_fault_q, rsp_fault_d;

  // Request decode
  logic [1:0]      dec_size;
  logic            dec_sign;
  logic            dec_legal;
  logic [3:0]      req_bytes;
  logic [OFFW-1:0] req_off;
  logic            req_misal;
`ifdef LSU_MISALIGN_SPLIT_EN
  logic            req_cross;
`endif

  always_comb begin
    dec_size  = 2'd0;
    dec_sign  = 1'b0;
    dec_legal = 1'b0;
    if (req_we) begin
      dec_size  = req_funct3[1:0];
      dec_legal = !req_funct3[2] && ((req_funct3[1:0] != 2'b11) || (XLEN == 64));
    end else begin
      case (req_funct3)
        3'b000:  begin dec_size = 2'd0; dec_sign = 1'b1; dec_legal = 1'b1; end
        3'b001:  begin dec_size = 2'd1; dec_sign = 1'b1; dec_legal = 1'b1; end
        3'b010:  begin dec_size = 2'd2; dec_sign = 1'b1; dec_legal = 1'b1; end
        3'b011:  begin dec_size = 2'd3; dec_sign = 1'b1; dec_legal = (XLEN == 64); end
        3'b100:  begin dec_size = 2'd0; dec_legal = 1'b1; end
        3'b101:  begin dec_size = 2'd1; dec_legal = 1'b1; end
        3'b110:  begin dec_size = 2'd2; dec_legal = (XLEN == 64); end
        default: dec_legal = 1'b0;
      endcase
    end
    req_bytes = 4'd1 << dec_size;
    req_off   = req_addr[OFFW-1:0];
    req_misal = (req_off & OFFW'(req_bytes - 4'd1)) != '0;
`ifdef LSU_MISALIGN_SPLIT_EN
    req_cross = (32'(req_off) + 32'(req_bytes)) > NB;
`endif
  end

  // Datapath driven from captured request state
  logic [3:0]          acc_bytes;
  logic [OFFW+2:0]     shamt;
  logic [BW-1:0]       be_wide;
  logic [2*XLEN-1:0]   wd_wide;
  logic [2*XLEN-1:0]   rd_wide;
  logic [XLEN-1:0]     rd_low;
  logic [XLEN-1:0]     keep;
  logic                sbit;
  logic [XLEN-1:0]     load_data;

  always_comb begin
    acc_bytes = 4'd1 << size_q;
    shamt     = {off_q, 3'b000};
    be_wide   = BW'((16'd1 << acc_bytes) - 16'd1) << off_q;
    wd_wide   = {{XLEN{1'b0}}, wdata_q} << shamt;
    // Second half of a split load lands in the upper word before the shift
    rd_wide   = (state_q == StAccess2) ? {mem_rdata, lo_q} : {{XLEN{1'b0}}, mem_rdata};
    rd_low    = XLEN'(rd_wide >> shamt);
    case (size_q)
      2'd0:    begin keep = XLEN'(8'hFF);         sbit = rd_low[7];      end
      2'd1:    begin keep = XLEN'(16'hFFFF);      sbit = rd_low[15];     end
      2'd2:    begin keep = XLEN'(32'hFFFF_FFFF); sbit = rd_low[31];     end
      default: begin keep = '1;                   sbit = rd_low[XLEN-1]; end
    endcase
    load_data = (rd_low & keep) | ((sign_q && sbit) ? ~keep : '0);
  end

  always_comb begin
    req_ready = (state_q == StIdle) && reset;
    rsp_valid = (state_q == StResp);
    rsp_rdata = rsp_rdata_q;
    rsp_fault = rsp_fault_q;
    mem_valid = (state_q == StAccess) || (state_q == StAccess2);
    mem_we    = mem_valid && we_q;
    mem_addr  = (state_q == StAccess2) ? base_q + XLEN'(NB) : base_q;
    mem_be    = '0;
    mem_wdata = '0;
    if (state_q == StAccess) begin
      mem_be    = be_wide[NB-1:0];
      mem_wdata = wd_wide[XLEN-1:0];
    end else if (state_q == StAccess2) begin
      mem_be    = be_wide[BW-1:NB];
      mem_wdata = wd_wide[2*XLEN-1:XLEN];
    end
  end

  always_comb begin
    logic fault;
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    sign_d      = sign_q;
    base_d      = base_q;
    off_d       = off_q;
    wdata_d     = wdata_q;
    cross_d     = cross_q;
    lo_d        = lo_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_fault_d = rsp_fault_q;
    fault       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = dec_size;
          sign_d  = dec_sign;
          base_d  = {req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
          off_d   = req_off;
          wdata_d = req_wdata;
`ifdef LSU_MISALIGN_SPLIT_EN
          fault   = !dec_legal;
          cross_d = req_cross;
`else
          fault   = !dec_legal || req_misal;
`endif
          if (fault) begin
            rsp_fault_d = 1'b1;
            rsp_rdata_d = '0;
            state_d     = StResp;
          end else begin
            state_d = StAccess;
          end
        end
      end
      StAccess: begin
        if (mem_ready) begin
          if (cross_q) begin
            lo_d    = mem_rdata;
            state_d = StAccess2;
          end else begin
            rsp_fault_d = 1'b0;
            rsp_rdata_d = we_q ? '0 : load_data;
            state_d     = StResp;
          end
        end
      end
      StAccess2: begin
        if (mem_ready) begin
          rsp_fault_d = 1'b0;
          rsp_rdata_d = we_q ? '0 : load_data;
          state_d     = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      we_q        <= 1'b0;
      size_q      <= 2'd0;
      sign_q      <= 1'b0;
      base_q      <= '0;
      off_q       <= '0;
      wdata_q     <= '0;
      cross_q     <= 1'b0;
      lo_q        <= '0;
      rsp_rdata_q <= '0;
      rsp_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      sign_q      <= sign_d;
      base_q      <= base_d;
      off_q       <= off_d;
      wdata_q     <= wdata_d;
      cross_q     <= cross_d;
      lo_q        <= lo_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_fault_q <= rsp_fault_d;
    end
  end

endmodule
